// File: rtl/sobel_result_writer.sv
`default_nettype none
// ============================================================================
// Module   : sobel_result_writer
// Brief    : Writes a stream of Sobel magnitude pixels to frame memory in
//            raster order, buffering through a small FIFO for back-pressure.
// Revision : 1.0 - initial release
// ============================================================================
module sobel_result_writer #(
    parameter int IMG_WIDTH  = 128,
    parameter int IMG_HEIGHT = 128,
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Start,
    input  logic              In_Valid,
    input  logic [7:0]        In_Pixel,
    output logic              In_Ready,
    output logic              Mem_We,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [7:0]        Mem_Data,
    input  logic              Mem_Ready,
    output logic [7:0]        Out_Row_Value,
    output logic [7:0]        Out_Column_Value,
    output logic              Busy,
    output logic              Frame_Done
);

    localparam int                 c_TOTAL     = IMG_WIDTH * IMG_HEIGHT;
    localparam int                 c_CNT_W     = $clog2(c_TOTAL + 1);
    localparam int                 c_PTR_W     = $clog2(FIFO_DEPTH);
    localparam int                 c_OCC_W     = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_TOTAL_CNT = c_CNT_W'(c_TOTAL);
    localparam logic [c_OCC_W-1:0] c_FULL_OCC  = c_OCC_W'(FIFO_DEPTH);
    localparam logic [7:0]         c_LAST_COL  = 8'(IMG_WIDTH - 1);
    localparam logic [7:0]         c_LAST_ROW  = 8'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [7:0]         r_fifo_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_OCC_W-1:0] r_occ;
    logic [c_CNT_W-1:0] r_accept_cnt;
    logic [7:0]         r_row;
    logic [7:0]         r_col;

    logic               w_run;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_last_pos;
    logic               w_arm;

    // Full uses registered occupancy only, so a simultaneous pop never opens a slot
    assign w_run      = (r_state == RUN);
    assign w_full     = (r_occ == c_FULL_OCC);
    assign w_empty    = (r_occ == '0);
    assign w_last_pos = (r_row == c_LAST_ROW) && (r_col == c_LAST_COL);
    assign w_arm      = (r_state == IDLE) && Start;

    assign In_Ready   = w_run && !w_full && (r_accept_cnt < c_TOTAL_CNT);
    assign Mem_We     = w_run && !w_empty;
    assign w_push     = In_Valid && In_Ready;
    assign w_pop      = Mem_We && Mem_Ready;

    assign Mem_Addr         = ADDR_W'(r_row) * ADDR_W'(IMG_WIDTH) + ADDR_W'(r_col);
    assign Mem_Data         = Mem_We ? r_fifo_mem[r_rd_ptr] : 8'h00;
    assign Out_Row_Value    = r_row;
    assign Out_Column_Value = r_col;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        Busy         = 1'b0;
        Frame_Done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (Start) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                Busy = 1'b1;
                if (w_pop && w_last_pos) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                Frame_Done   = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Storage needs no reset: Mem_Data is forced to zero whenever the FIFO is empty
    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= In_Pixel;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_occ        <= '0;
            r_accept_cnt <= '0;
            r_row        <= '0;
            r_col        <= '0;
        end else if (w_arm) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_occ        <= '0;
            r_accept_cnt <= '0;
            r_row        <= '0;
            r_col        <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr     <= r_wr_ptr + c_PTR_W'(1);
                r_accept_cnt <= r_accept_cnt + c_CNT_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                if (r_col == c_LAST_COL) begin
                    r_col <= '0;
                    r_row <= (r_row == c_LAST_ROW) ? 8'd0 : r_row + 8'd1;
                end else begin
                    r_col <= r_col + 8'd1;
                end
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + c_OCC_W'(1);
                2'b01:   r_occ <= r_occ - c_OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sobel_result_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobel_result_writer
// Brief    : Self-checking bench: 4x3 directed scenarios plus a randomized
//            128x128 frame against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sobel_result_writer;

    localparam int S_W   = 4;
    localparam int S_H   = 3;
    localparam int S_N   = S_W * S_H;
    localparam int DEPTH = 4;
    localparam int L_W   = 128;
    localparam int L_H   = 128;
    localparam int L_N   = L_W * L_H;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic        s_start = 1'b0, s_in_valid = 1'b0, s_mem_ready = 1'b0;
    logic [7:0]  s_in_pixel = 8'h00;
    logic        s_in_ready, s_mem_we, s_busy, s_done;
    logic [15:0] s_mem_addr;
    logic [7:0]  s_mem_data, s_row, s_col;

    logic        l_start = 1'b0, l_in_valid = 1'b0, l_mem_ready = 1'b0;
    logic [7:0]  l_in_pixel = 8'h00;
    logic        l_in_ready, l_mem_we, l_busy, l_done;
    logic [15:0] l_mem_addr;
    logic [7:0]  l_mem_data, l_row, l_col;

    // Reference model: accepted-but-unwritten pixels in order, plus counters
    logic [7:0] s_q[$];
    int         s_acc = 0, s_wr = 0;
    bit         s_run = 1'b0;
    logic [7:0] l_q[$];
    int         l_acc = 0, l_wr = 0;
    bit         l_run = 1'b0;

    sobel_result_writer #(.IMG_WIDTH(S_W), .IMG_HEIGHT(S_H), .ADDR_W(16), .FIFO_DEPTH(DEPTH)) dut_s (
        .Clk(clk), .Rst_n(rst_n), .Start(s_start), .In_Valid(s_in_valid), .In_Pixel(s_in_pixel),
        .In_Ready(s_in_ready), .Mem_We(s_mem_we), .Mem_Addr(s_mem_addr), .Mem_Data(s_mem_data),
        .Mem_Ready(s_mem_ready), .Out_Row_Value(s_row), .Out_Column_Value(s_col),
        .Busy(s_busy), .Frame_Done(s_done)
    );

    sobel_result_writer #(.IMG_WIDTH(L_W), .IMG_HEIGHT(L_H), .ADDR_W(16), .FIFO_DEPTH(DEPTH)) dut_l (
        .Clk(clk), .Rst_n(rst_n), .Start(l_start), .In_Valid(l_in_valid), .In_Pixel(l_in_pixel),
        .In_Ready(l_in_ready), .Mem_We(l_mem_we), .Mem_Addr(l_mem_addr), .Mem_Data(l_mem_data),
        .Mem_Ready(l_mem_ready), .Out_Row_Value(l_row), .Out_Column_Value(l_col),
        .Busy(l_busy), .Frame_Done(l_done)
    );

    // One clock on the small instance: drive at negedge, sample handshakes, advance
    task automatic tick_s(input logic v, input logic [7:0] p, input logic mr, input logic st,
                          output logic acc, output logic wr, output logic [15:0] wa, output logic [7:0] wd);
        s_in_valid = v; s_in_pixel = p; s_mem_ready = mr; s_start = st;
        #1;
        acc = v && s_in_ready;
        wr  = s_mem_we && mr;
        wa  = s_mem_addr;
        wd  = s_mem_data;
        @(posedge clk);
        @(negedge clk);
        s_start = 1'b0;
        if (acc) begin
            s_q.push_back(p);
            s_acc++;
        end
    endtask

    task automatic tick_l(input logic v, input logic [7:0] p, input logic mr, input logic st,
                          output logic acc, output logic wr, output logic [15:0] wa, output logic [7:0] wd);
        l_in_valid = v; l_in_pixel = p; l_mem_ready = mr; l_start = st;
        #1;
        acc = v && l_in_ready;
        wr  = l_mem_we && mr;
        wa  = l_mem_addr;
        wd  = l_mem_data;
        @(posedge clk);
        @(negedge clk);
        l_start = 1'b0;
        if (acc) begin
            l_q.push_back(p);
            l_acc++;
        end
    endtask

    task automatic model_start_s();
        s_run = 1'b1; s_acc = 0; s_wr = 0; s_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_cnt++;
        if ({s_in_ready, s_mem_we, s_busy, s_done} !== 4'b0000)
            $display("FAIL reset_ctrl: got %b expected 0000", {s_in_ready, s_mem_we, s_busy, s_done});
        else pass_cnt++;
        chk_cnt++;
        if ({s_mem_addr, s_mem_data} !== 24'h0)
            $display("FAIL reset_mem: got addr %0h data %0h expected 0 0", s_mem_addr, s_mem_data);
        else pass_cnt++;
        chk_cnt++;
        if ({s_row, s_col} !== 16'h0)
            $display("FAIL reset_pos: got row %0d col %0d expected 0 0", s_row, s_col);
        else pass_cnt++;
        chk_cnt++;
        if ({l_in_ready, l_mem_we, l_busy, l_done, l_mem_addr, l_mem_data, l_row, l_col} !== 44'h0)
            $display("FAIL reset_large: got %0h expected 0",
                     {l_in_ready, l_mem_we, l_busy, l_done, l_mem_addr, l_mem_data, l_row, l_col});
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if ({s_in_ready, s_mem_we, s_busy} !== 3'b000)
            $display("FAIL idle_after_reset: got %b expected 000", {s_in_ready, s_mem_we, s_busy});
        else pass_cnt++;
    endtask

    task automatic test_frame();
        logic acc, wr;
        logic [15:0] wa;
        logic [7:0] wd, exp_d;
        int pix = 0, cyc = 0, done_seen = 0;
        tick_s(1'b0, 8'h00, 1'b1, 1'b1, acc, wr, wa, wd);
        model_start_s();
        chk_cnt++;
        if ({s_busy, s_in_ready, s_mem_we} !== 3'b110)
            $display("FAIL start_resp: got %b expected 110", {s_busy, s_in_ready, s_mem_we});
        else pass_cnt++;
        while (s_wr < S_N && cyc < 100) begin
            // Start pulsed mid-frame must be ignored
            tick_s(1'b1, 8'(pix), 1'b1, (cyc == 5), acc, wr, wa, wd);
            cyc++;
            if (acc) pix++;
            if (s_done) done_seen++;
            if (cyc == 1) begin
                chk_cnt++;
                if ({s_mem_we, s_mem_data} !== {1'b1, 8'h00})
                    $display("FAIL first_latency: got we %b data %0h expected 1 0", s_mem_we, s_mem_data);
                else pass_cnt++;
            end
            if (wr) begin
                exp_d = (s_q.size() > 0) ? s_q[0] : 8'h00;
                chk_cnt++;
                if (wa !== 16'(s_wr) || wd !== 8'(s_wr) || s_q.size() == 0 || wd !== exp_d)
                    $display("FAIL frame_write: got addr %0d data %0h expected addr %0d data %0h",
                             wa, wd, s_wr, exp_d);
                else pass_cnt++;
                if (s_q.size() > 0) void'(s_q.pop_front());
                s_wr++;
                if (s_wr == S_N) s_run = 1'b0;
                if (s_wr == 4 || s_wr == 8) begin
                    chk_cnt++;
                    if ({s_row, s_col, s_mem_addr} !== {8'(s_wr / S_W), 8'd0, 16'(s_wr)})
                        $display("FAIL row_wrap: got row %0d col %0d addr %0d expected row %0d col 0 addr %0d",
                                 s_row, s_col, s_mem_addr, s_wr / S_W, s_wr);
                    else pass_cnt++;
                end
            end
            chk_cnt++;
            if (s_in_ready !== (s_run && s_q.size() < DEPTH && s_acc < S_N))
                $display("FAIL frame_in_ready: got %b expected %b", s_in_ready,
                         (s_run && s_q.size() < DEPTH && s_acc < S_N));
            else pass_cnt++;
        end
        chk_cnt++;
        if (cyc !== S_N + 1)
            $display("FAIL throughput: got %0d cycles expected %0d", cyc, S_N + 1);
        else pass_cnt++;
        chk_cnt++;
        if ({s_done, s_busy, done_seen} !== {1'b1, 1'b0, 32'd1})
            $display("FAIL frame_done: got done %b busy %b pulses %0d expected 1 0 1", s_done, s_busy, done_seen);
        else pass_cnt++;
        chk_cnt++;
        if (s_acc !== S_N)
            $display("FAIL overrun_count: got %0d expected %0d", s_acc, S_N);
        else pass_cnt++;
        tick_s(1'b1, 8'hAA, 1'b1, 1'b0, acc, wr, wa, wd);
        chk_cnt++;
        if ({acc, s_done, s_busy, s_in_ready, s_mem_we, s_row, s_col} !== 13'h0)
            $display("FAIL after_done: got acc %b done %b busy %b rdy %b we %b row %0d col %0d expected all 0",
                     acc, s_done, s_busy, s_in_ready, s_mem_we, s_row, s_col);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic acc, wr;
        logic [15:0] wa;
        logic [7:0] wd, exp_d;
        int cyc = 0;
        tick_s(1'b0, 8'h00, 1'b0, 1'b1, acc, wr, wa, wd);
        model_start_s();
        for (int i = 0; i < 10; i++) begin
            tick_s(1'b1, 8'($urandom), 1'b0, 1'b0, acc, wr, wa, wd);
            if (s_q.size() > 0) begin
                chk_cnt++;
                if ({s_mem_we, s_mem_addr, s_mem_data} !== {1'b1, 16'd0, s_q[0]})
                    $display("FAIL stall_stable: got we %b addr %0d data %0h expected 1 0 %0h",
                             s_mem_we, s_mem_addr, s_mem_data, s_q[0]);
                else pass_cnt++;
            end
        end
        chk_cnt++;
        if ({s_in_ready, 32'(s_acc)} !== {1'b0, 32'(DEPTH)})
            $display("FAIL stall_fill: got ready %b accepted %0d expected 0 %0d", s_in_ready, s_acc, DEPTH);
        else pass_cnt++;
        while (s_wr < S_N && cyc < 200) begin
            tick_s(1'($urandom_range(0, 1)), 8'($urandom), 1'b1, (cyc == 3), acc, wr, wa, wd);
            cyc++;
            if (wr) begin
                exp_d = (s_q.size() > 0) ? s_q[0] : 8'h00;
                chk_cnt++;
                if (wa !== 16'(s_wr) || s_q.size() == 0 || wd !== exp_d)
                    $display("FAIL drain_write: got addr %0d data %0h expected addr %0d data %0h",
                             wa, wd, s_wr, exp_d);
                else pass_cnt++;
                if (s_q.size() > 0) void'(s_q.pop_front());
                s_wr++;
                if (s_wr == S_N) s_run = 1'b0;
            end
            chk_cnt++;
            if (s_in_ready !== (s_run && s_q.size() < DEPTH && s_acc < S_N))
                $display("FAIL drain_in_ready: got %b expected %b", s_in_ready,
                         (s_run && s_q.size() < DEPTH && s_acc < S_N));
            else pass_cnt++;
        end
        chk_cnt++;
        if ({s_done, 32'(s_wr)} !== {1'b1, 32'(S_N)})
            $display("FAIL drain_done: got done %b writes %0d expected 1 %0d", s_done, s_wr, S_N);
        else pass_cnt++;
        tick_s(1'b0, 8'h00, 1'b0, 1'b0, acc, wr, wa, wd);
    endtask

    task automatic test_reset_midframe();
        logic acc, wr;
        logic [15:0] wa;
        logic [7:0] wd, exp_d;
        int cyc = 0;
        tick_s(1'b0, 8'h00, 1'b1, 1'b1, acc, wr, wa, wd);
        model_start_s();
        while (s_wr < 6 && cyc < 50) begin
            tick_s(1'b1, 8'($urandom), 1'b1, 1'b0, acc, wr, wa, wd);
            cyc++;
            if (wr) s_wr++;
        end
        s_in_valid = 1'b0; s_mem_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({s_in_ready, s_mem_we, s_busy, s_done, s_mem_addr, s_mem_data, s_row, s_col} !== 44'h0)
            $display("FAIL midframe_reset: got %0h expected 0",
                     {s_in_ready, s_mem_we, s_busy, s_done, s_mem_addr, s_mem_data, s_row, s_col});
        else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        s_run = 1'b0; s_q.delete();
        tick_s(1'b0, 8'h00, 1'b1, 1'b1, acc, wr, wa, wd);
        model_start_s();
        chk_cnt++;
        if ({s_busy, s_mem_we, s_mem_addr} !== {1'b1, 1'b0, 16'd0})
            $display("FAIL restart: got busy %b we %b addr %0d expected 1 0 0", s_busy, s_mem_we, s_mem_addr);
        else pass_cnt++;
        cyc = 0;
        while (s_wr < S_N && cyc < 100) begin
            tick_s(1'b1, 8'($urandom), 1'b1, 1'b0, acc, wr, wa, wd);
            cyc++;
            if (wr) begin
                exp_d = (s_q.size() > 0) ? s_q[0] : 8'h00;
                chk_cnt++;
                if (wa !== 16'(s_wr) || s_q.size() == 0 || wd !== exp_d)
                    $display("FAIL restart_write: got addr %0d data %0h expected addr %0d data %0h",
                             wa, wd, s_wr, exp_d);
                else pass_cnt++;
                if (s_q.size() > 0) void'(s_q.pop_front());
                s_wr++;
                if (s_wr == S_N) s_run = 1'b0;
            end
        end
        chk_cnt++;
        if ({s_done, 32'(s_wr)} !== {1'b1, 32'(S_N)})
            $display("FAIL restart_done: got done %b writes %0d expected 1 %0d", s_done, s_wr, S_N);
        else pass_cnt++;
        tick_s(1'b0, 8'h00, 1'b0, 1'b0, acc, wr, wa, wd);
    endtask

    task automatic test_random_large();
        logic acc, wr;
        logic [15:0] wa;
        logic [7:0] wd, exp_d;
        int cyc = 0, done_seen = 0;
        tick_l(1'b0, 8'h00, 1'b0, 1'b1, acc, wr, wa, wd);
        l_run = 1'b1; l_acc = 0; l_wr = 0; l_q.delete();
        while (l_wr < L_N && cyc < 70000) begin
            tick_l(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, acc, wr, wa, wd);
            cyc++;
            if (l_done) done_seen++;
            if (wr) begin
                exp_d = (l_q.size() > 0) ? l_q[0] : 8'h00;
                chk_cnt++;
                if (wa !== 16'(l_wr) || l_q.size() == 0 || wd !== exp_d)
                    $display("FAIL random_write: got addr %0d data %0h expected addr %0d data %0h",
                             wa, wd, l_wr, exp_d);
                else pass_cnt++;
                if (l_q.size() > 0) void'(l_q.pop_front());
                l_wr++;
                if (l_wr == L_N) l_run = 1'b0;
                if (l_wr < L_N) begin
                    chk_cnt++;
                    if ({l_row, l_col} !== {8'(l_wr / L_W), 8'(l_wr % L_W)})
                        $display("FAIL random_pos: got row %0d col %0d expected row %0d col %0d",
                                 l_row, l_col, l_wr / L_W, l_wr % L_W);
                    else pass_cnt++;
                end
            end
            chk_cnt++;
            if (l_in_ready !== (l_run && l_q.size() < DEPTH && l_acc < L_N))
                $display("FAIL random_in_ready: got %b expected %b", l_in_ready,
                         (l_run && l_q.size() < DEPTH && l_acc < L_N));
            else pass_cnt++;
        end
        chk_cnt++;
        if ({l_done, l_busy, 32'(l_wr), done_seen} !== {1'b1, 1'b0, 32'(L_N), 32'd1})
            $display("FAIL random_done: got done %b busy %b writes %0d pulses %0d expected 1 0 %0d 1",
                     l_done, l_busy, l_wr, done_seen, L_N);
        else pass_cnt++;
        tick_l(1'b1, 8'h00, 1'b1, 1'b0, acc, wr, wa, wd);
        chk_cnt++;
        if ({acc, l_done, l_in_ready} !== 3'b000)
            $display("FAIL random_idle: got acc %b done %b rdy %b expected 000", acc, l_done, l_in_ready);
        else pass_cnt++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_frame();
        test_backpressure();
        test_reset_midframe();
        test_random_large();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sobel_result_writer.md
# sobel_result_writer

Write-side counterpart of the Sobel row/column address walker: accepts the stream of 8-bit Sobel magnitude pixels produced by the edge-detection datapath and writes them to the output frame memory in raster order. The block generates the packed row/column position itself, converts it to a linear write address, and absorbs memory back-pressure through a small FIFO. It sits between the Sobel kernel output and the result RAM, and flags end of frame to the top-level controller.

## Interface
- IMG_WIDTH, 128: pixels per row, 2..256
- IMG_HEIGHT, 128: rows per frame, 2..256
- ADDR_W, 16: memory address width, at least log2(IMG_WIDTH*IMG_HEIGHT)
- FIFO_DEPTH, 4: pixel buffer entries, power of two, at least 2
- Clk  input  1  single clock, rising edge
- Rst_n  input  1  asynchronous active-low reset
- Start  input  1  one-cycle pulse arming a frame; honoured only in IDLE
- In_Valid  input  1  pixel present on In_Pixel
- In_Pixel  input  8  Sobel magnitude pixel
- In_Ready  output  1  block accepts pixel this cycle
- Mem_We  output  1  write request
- Mem_Addr  output  ADDR_W  linear write address
- Mem_Data  output  8  write data
- Mem_Ready  input  1  memory takes the write this cycle
- Out_Row_Value  output  8  row of the next write
- Out_Column_Value  output  8  column of the next write
- Busy  output  1  high in RUN
- Frame_Done  output  1  one-cycle pulse after the last write

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: In_Ready=0, Mem_We=0. Start=1 -> RUN; accept counter, row and column cleared.
- RUN: input accept when In_Valid && In_Ready; In_Ready = RUN && FIFO not full && accept count < IMG_WIDTH*IMG_HEIGHT. Accepted pixel is pushed into the FIFO.
- Write side: Mem_We = RUN && FIFO not empty; Mem_Data = FIFO head; Mem_Addr = row*IMG_WIDTH + column, zero-extended to ADDR_W. A write completes when Mem_We && Mem_Ready: pop FIFO, advance position.
- Position advance: column+1; if column == IMG_WIDTH-1, column -> 0 and row+1. A write completing at row IMG_HEIGHT-1, column IMG_WIDTH-1 -> DONE; row and column -> 0.
- DONE: lasts one cycle, Frame_Done=1, then IDLE.
- While Mem_We=1 and Mem_Ready=0, Mem_Addr, Mem_Data and Mem_We hold stable.
- Push and pop in the same cycle are both honoured; the occupancy count is unchanged.
- Full is evaluated on registered occupancy; no bypass into a full FIFO, even when a pop occurs that cycle.
- Pixels offered beyond the frame count are not accepted; In_Ready stays 0 until the next frame.
- Start outside IDLE is ignored.

## Timing
- Reset values: state IDLE, FIFO empty, In_Ready=0, Mem_We=0, Mem_Addr=0, Mem_Data=0, Out_Row_Value=0, Out_Column_Value=0, Busy=0, Frame_Done=0.
- Start sampled at edge N -> Busy and In_Ready high in cycle N+1 (In_Ready is subject to the FIFO-full and frame-count conditions).
- Pixel accepted at edge N -> first presented on Mem_Data with Mem_We=1 in cycle N+1 if the FIFO was empty.
- Throughput: 1 pixel/cycle sustained with Mem_Ready held high.
- Last write completes at edge M -> Frame_Done=1 and Busy=0 in cycle M+1 (DONE). State is IDLE in cycle M+2.
- Rst_n low at any time, including mid-frame: immediate return to reset values. FIFO contents and position are discarded. No partial resume.

## Test plan
- Run with IMG_WIDTH=4, IMG_HEIGHT=3. Start, then 12 pixels 0x00..0x0B back-to-back with Mem_Ready=1 -> 12 writes, addresses 0..11, data equal to address. Frame_Done pulses once, one cycle after the write to address 11.
- Row wrap: after 4 writes -> Out_Row_Value=1, Out_Column_Value=0, Mem_Addr=4. After 8 writes -> row 2, Mem_Addr=8.
- Back-pressure: Mem_Ready=0 for 10 cycles while In_Valid=1 -> exactly FIFO_DEPTH=4 pixels accepted, then In_Ready=0. Mem_Addr, Mem_Data and Mem_We stable throughout. Releasing Mem_Ready drains the FIFO in order with no loss or duplication.
- Overrun: In_Valid held high after the 12th pixel -> no 13th accept. Start pulsed during RUN -> ignored, addresses continue unchanged.
- Reset mid-frame: Rst_n low after the 6th write -> all outputs 0 immediately. A new Start then restarts at address 0 with an empty FIFO.
- Random In_Valid/Mem_Ready (50%) over a full 128x128 frame -> 16384 writes, addresses 0..16383 strictly increasing, data matching input order.
